// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS encoding constants for the decoders and the program loader:
//   - mnemonic_t : the 4-bit mnemonic code carried on the loader input stream
//   - OP_* / FN_* : primary opcodes and R-type function codes
//   - LD_*        : program loader FSM state encodings
//   - r_type / i_type / j_type : helpers that assemble a 32-bit word from fields
// -----------------------------------------------------------------------------
package mips_pkg;

    // Mnemonic codes 12..15 are unused and are treated as illegal by the loader.
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_LW   = 4'd5,
        MN_SW   = 4'd6,
        MN_BEQ  = 4'd7,
        MN_BNE  = 4'd8,
        MN_ADDI = 4'd9,
        MN_J    = 4'd10,
        MN_ORI  = 4'd11
    } mnemonic_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // Loader FSM states.
    localparam logic [1:0] LD_IDLE  = 2'd0;
    localparam logic [1:0] LD_LOAD  = 2'd1;
    localparam logic [1:0] LD_DONE  = 2'd2;
    localparam logic [1:0] LD_ERR   = 2'd3;

    function automatic logic [31:0] r_type(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// -----------------------------------------------------------------------------
// mips_instr_encoder
// Purely combinational inverse of the main decoder: turns a mnemonic plus its
// register/immediate/target fields into the 32-bit MIPS instruction word.
// Ports:
//   mnem    in  4   mnemonic code (mnemonic_t values 0..11)
//   rs      in  5   source register
//   rt      in  5   second source / destination register (I-type)
//   rd      in  5   destination register (R-type only)
//   imm     in  16  immediate / branch offset (I-type)
//   target  in  26  jump target (J only)
//   word    out 32  encoded instruction (0 when illegal)
//   legal   out 1   1 when mnem is one of the twelve supported mnemonics
// -----------------------------------------------------------------------------
module mips_instr_encoder
    import mips_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Unused mnemonic codes fall through to the default and report illegal.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (mnem)
            MN_ADD:  word = r_type(rs, rt, rd, FN_ADD);
            MN_SUB:  word = r_type(rs, rt, rd, FN_SUB);
            MN_AND:  word = r_type(rs, rt, rd, FN_AND);
            MN_OR:   word = r_type(rs, rt, rd, FN_OR);
            MN_SLT:  word = r_type(rs, rt, rd, FN_SLT);
            MN_LW:   word = i_type(OP_LW,   rs, rt, imm);
            MN_SW:   word = i_type(OP_SW,   rs, rt, imm);
            MN_BEQ:  word = i_type(OP_BEQ,  rs, rt, imm);
            MN_BNE:  word = i_type(OP_BNE,  rs, rt, imm);
            MN_ADDI: word = i_type(OP_ADDI, rs, rt, imm);
            MN_ORI:  word = i_type(OP_ORI,  rs, rt, imm);
            MN_J:    word = j_type(target);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_program_loader.sv
// -----------------------------------------------------------------------------
// mips_program_loader
// Accepts instruction field bundles over a valid/ready stream, encodes them and
// writes them sequentially into instruction memory starting at word 0. The
// single-cycle CPU is held in reset until the program is complete.
// Parameters:
//   ADDR_W      imem word-address width (DEPTH = 2**ADDR_W words)
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous, active-high
//   start       in   1       pulse: (re)start loading at word 0
//   in_valid    in   1       field bundle valid
//   in_ready    out  1       bundle accepted this cycle when valid
//   in_mnem     in   4       mnemonic code
//   in_rs/rt/rd in   5       register fields
//   in_imm      in   16      immediate / offset
//   in_target   in   26      jump target
//   in_last     in   1       bundle is the last instruction of the program
//   imem_we     out  1       imem write strobe (one cycle per word)
//   imem_addr   out  ADDR_W  imem word address
//   imem_wdata  out  32      encoded instruction
//   cpu_hold    out  1       1 = keep CPU in reset
//   done        out  1       program loaded, CPU released
//   error       out  1       illegal mnemonic received
//   full        out  1       imem filled without in_last
// -----------------------------------------------------------------------------
module mips_program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic              full
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;

    mips_instr_encoder u_encoder (
        .mnem   (in_mnem),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .word   (enc_word),
        .legal  (enc_legal)
    );

    // A start in the same cycle as a valid bundle restarts the load, so the
    // bundle must not be acknowledged; ready is dropped during reset as well.
    assign in_ready = (state == LD_LOAD) && !start && !reset;
    assign accept   = in_valid && in_ready;

    // Only the terminal states release or flag anything; IDLE and LOAD both
    // keep the CPU held.
    assign done     = (state == LD_DONE);
    assign error    = (state == LD_ERR);
    assign cpu_hold = (state != LD_DONE);

    // Pointer only advances while there is room left; the last word of the
    // memory completes the load instead of wrapping back to word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_IDLE;
            ptr        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0000_0000;
            full       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                state <= LD_LOAD;
                ptr   <= '0;
                full  <= 1'b0;
            end else if (accept) begin
                if (!enc_legal) begin
                    state <= LD_ERR;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc_word;
                    if (in_last) begin
                        state <= LD_DONE;
                    end else if (ptr == {ADDR_W{1'b1}}) begin
                        state <= LD_DONE;
                        full  <= 1'b1;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// -----------------------------------------------------------------------------
// tb_mips_program_loader
// Drives two loaders (64-word and 4-word imem) from one stream. A behavioural
// model predicts every output each cycle; hand-computed instruction words pin
// the model's encoding.
// -----------------------------------------------------------------------------
module tb_mips_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        dut_ready [2];
    logic        dut_we    [2];
    logic        dut_hold  [2];
    logic        dut_done  [2];
    logic        dut_err   [2];
    logic        dut_full  [2];
    logic [31:0] dut_data  [2];
    logic [31:0] dut_addr  [2];
    logic [5:0]  addr0;
    logic [1:0]  addr1;

    int compared   = 0;
    int mismatched = 0;

    assign dut_addr[0] = {26'd0, addr0};
    assign dut_addr[1] = {30'd0, addr1};

    mips_program_loader #(.ADDR_W(6)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(dut_ready[0]), .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(dut_we[0]), .imem_addr(addr0), .imem_wdata(dut_data[0]),
        .cpu_hold(dut_hold[0]), .done(dut_done[0]), .error(dut_err[0]), .full(dut_full[0])
    );

    mips_program_loader #(.ADDR_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(dut_ready[1]), .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(dut_we[1]), .imem_addr(addr1), .imem_wdata(dut_data[1]),
        .cpu_hold(dut_hold[1]), .done(dut_done[1]), .error(dut_err[1]), .full(dut_full[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    int          m_mode  [2] = '{M_IDLE, M_IDLE};
    int          m_ptr   [2] = '{0, 0};
    int          m_depth [2] = '{64, 4};
    bit          m_we    [2];
    bit          m_full  [2];
    int          m_addr  [2];
    logic [31:0] m_data  [2];

    int op_tab    [12] = '{0, 0, 0, 0, 0, 35, 43, 4, 5, 8, 2, 13};
    int funct_tab [5]  = '{32, 34, 36, 37, 42};

    function automatic logic [31:0] expect_word(input int mn, input int rs_v, input int rt_v,
                                                input int rd_v, input int imm_v, input int tgt_v);
        logic [31:0] w;
        if (mn == 10) begin
            w = (32'(2) << 26) | 32'(tgt_v);
        end else begin
            w = (32'(op_tab[mn]) << 26) | (32'(rs_v) << 21) | (32'(rt_v) << 16);
            if (mn < 5) w = w | (32'(rd_v) << 11) | 32'(funct_tab[mn]);
            else        w = w | 32'(imm_v);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mode[i] = M_IDLE; m_ptr[i] = 0; m_we[i] = 0;
                m_addr[i] = 0; m_data[i] = 0; m_full[i] = 0;
            end else begin
                m_we[i] = 0;
                if (start) begin
                    m_mode[i] = M_LOAD; m_ptr[i] = 0; m_full[i] = 0;
                end else if (m_mode[i] == M_LOAD && in_valid) begin
                    if (int'(in_mnem) > 11) begin
                        m_mode[i] = M_ERR;
                    end else begin
                        m_we[i]   = 1;
                        m_addr[i] = m_ptr[i];
                        m_data[i] = expect_word(int'(in_mnem), int'(in_rs), int'(in_rt),
                                                int'(in_rd), int'(in_imm), int'(in_target));
                        if (in_last) begin
                            m_mode[i] = M_DONE;
                        end else if (m_ptr[i] == m_depth[i] - 1) begin
                            m_mode[i] = M_DONE;
                            m_full[i] = 1;
                        end else begin
                            m_ptr[i]++;
                        end
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check_output($sformatf("u%0d.in_ready", i), 32'(dut_ready[i]),
                         32'(m_mode[i] == M_LOAD && !start && !reset));
            check_output($sformatf("u%0d.imem_we", i), 32'(dut_we[i]), 32'(m_we[i]));
            check_output($sformatf("u%0d.cpu_hold", i), 32'(dut_hold[i]), 32'(m_mode[i] != M_DONE));
            check_output($sformatf("u%0d.done", i), 32'(dut_done[i]), 32'(m_mode[i] == M_DONE));
            check_output($sformatf("u%0d.error", i), 32'(dut_err[i]), 32'(m_mode[i] == M_ERR));
            check_output($sformatf("u%0d.full", i), 32'(dut_full[i]), 32'(m_full[i]));
            if (m_we[i] || reset) begin
                check_output($sformatf("u%0d.imem_addr", i), dut_addr[i], 32'(m_addr[i]));
                check_output($sformatf("u%0d.imem_wdata", i), dut_data[i], m_data[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input bit st, input bit v, input int mn, input int rs_v,
                                  input int rt_v, input int rd_v, input int imm_v,
                                  input int tgt_v, input bit last);
        @(negedge clk);
        start     = st;
        in_valid  = v;
        in_mnem   = 4'(mn);
        in_rs     = 5'(rs_v);
        in_rt     = 5'(rt_v);
        in_rd     = 5'(rd_v);
        in_imm    = 16'(imm_v);
        in_target = 26'(tgt_v);
        in_last   = last;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_start();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_mnem = 4'd0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0;
        in_target = 26'd0; in_last = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        check_output("reset_hold", 32'(dut_hold[0]), 32'd1);
        check_output("reset_ready", 32'(dut_ready[0]), 32'd0);
        check_output("reset_we", 32'(dut_we[0]), 32'd0);
        check_output("reset_wdata", dut_data[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle: bundles are ignored.
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("idle_no_write", 32'(dut_we[0]), 32'd0);
        apply_stimulus(0, 1, 5, 0, 8, 0, 4, 0, 1);
        check_output("idle_still_held", 32'(dut_hold[0]), 32'd1);

        // ADD r3 = r1 + r2.
        do_start();
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("add_we", 32'(dut_we[0]), 32'd1);
        check_output("add_addr", dut_addr[0], 32'd0);
        check_output("add_word", dut_data[0], 32'h0022_1820);
        idle_cycle();

        // LW then J with in_last.
        do_start();
        apply_stimulus(0, 1, 5, 0, 8, 0, 4, 0, 0);
        check_output("lw_addr", dut_addr[0], 32'd0);
        check_output("lw_word", dut_data[0], 32'h8C08_0004);
        apply_stimulus(0, 1, 10, 0, 0, 0, 0, 0, 1);
        check_output("j_addr", dut_addr[0], 32'd1);
        check_output("j_word", dut_data[0], 32'h0800_0000);
        check_output("j_done", 32'(dut_done[0]), 32'd1);
        check_output("j_release", 32'(dut_hold[0]), 32'd0);
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("done_ignores", 32'(dut_we[0]), 32'd0);
        idle_cycle();

        // Remaining mnemonics; the 4-word loader fills up along the way.
        do_start();
        begin
            int mn_tab  [6] = '{2, 3, 4, 8, 9, 1};
            int imm_tab [6] = '{0, 0, 0, 16'h0010, 16'h8000, 0};
            for (int k = 0; k < 6; k++)
                apply_stimulus(0, 1, mn_tab[k], k + 3, k + 10, k + 20, imm_tab[k], 0, 0);
        end
        apply_stimulus(0, 1, 6, 29, 31, 0, 8, 0, 0);
        check_output("sw_word", dut_data[0], 32'hAFBF_0008);
        apply_stimulus(0, 1, 7, 1, 2, 0, 16'hFFFF, 0, 0);
        check_output("beq_word", dut_data[0], 32'h1022_FFFF);
        idle_cycle();

        // Illegal mnemonic at ptr 2.
        do_start();
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        apply_stimulus(0, 1, 1, 4, 5, 6, 0, 0, 0);
        apply_stimulus(0, 1, 13, 1, 1, 1, 0, 0, 0);
        check_output("illegal_no_write", 32'(dut_we[0]), 32'd0);
        check_output("illegal_error", 32'(dut_err[0]), 32'd1);
        check_output("illegal_ready", 32'(dut_ready[0]), 32'd0);
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        do_start();
        check_output("restart_clears_error", 32'(dut_err[0]), 32'd0);
        apply_stimulus(1, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("start_wins", 32'(dut_we[0]), 32'd0);
        apply_stimulus(0, 1, 3, 7, 8, 9, 0, 0, 0);
        check_output("restart_addr", dut_addr[0], 32'd0);
        idle_cycle();

        // Four ORI words into the 4-word memory without in_last.
        do_start();
        for (int k = 0; k < 4; k++)
            apply_stimulus(0, 1, 11, 1, 1, 0, 16'h00FF, 0, 0);
        check_output("ori_word", dut_data[1], 32'h3421_00FF);
        check_output("ori_last_addr", dut_addr[1], 32'd3);
        check_output("fill_full", 32'(dut_full[1]), 32'd1);
        check_output("fill_done", 32'(dut_done[1]), 32'd1);
        check_output("big_not_full", 32'(dut_full[0]), 32'd0);
        idle_cycle();

        // Reset in the middle of a load.
        do_start();
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        apply_stimulus(0, 1, 0, 4, 5, 6, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check_output("midreset_hold", 32'(dut_hold[0]), 32'd1);
        check_output("midreset_we", 32'(dut_we[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("post_reset_start_ignores", 32'(dut_we[0]), 32'd0);
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 0);
        check_output("post_reset_addr", dut_addr[0], 32'd0);
        idle_cycle();
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
